// File: rtl/goldschmidt_ctrl.sv
// goldschmidt_ctrl: sequencing FSM for the 16-bit Goldschmidt divider datapath
module goldschmidt_ctrl #(
  parameter int ITERS = 3,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dZero,
  output logic             ready,
  output logic             busy,
  output logic             ndSelect,
  output logic             kSelect,
  output logic             nEn,
  output logic             dEn,
  output logic             resultEn,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] iter
);
  typedef enum logic [2:0] {IDLE, LOAD, ITER, WB, DONE} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);
  state_t state, nxt;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic err_n;
  // state, pass counter and sticky error register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= cnt_n;
      err   <= err_n;
    end
  end
  // next state: a zero divisor skips the refinement passes and writeback
  always_comb begin
    nxt   = state;
    cnt_n = cnt;
    err_n = err;
    case (state)
      IDLE: if (start) begin
        nxt   = LOAD;
        err_n = 1'b0;
      end
      LOAD: if (dZero) begin
        nxt   = DONE;
        err_n = 1'b1;
      end else begin
        nxt   = (ITERS > 1) ? ITER : WB;
        cnt_n = CNT_W'(1);
      end
      ITER: if (cnt == LAST) nxt = WB;
            else cnt_n = cnt + 1'b1;
      WB:   nxt = DONE;
      DONE: begin
        nxt   = IDLE;
        cnt_n = '0;
      end
      default: nxt = IDLE;
    endcase
  end
  // Moore outputs decoded from the state register and counter
  always_comb begin
    ready    = state == IDLE;
    busy     = state == LOAD || state == ITER || state == WB;
    ndSelect = state == ITER;
    kSelect  = state == ITER;
    nEn      = state == LOAD || state == ITER;
    dEn      = state == LOAD || state == ITER;
    resultEn = state == WB;
    done     = state == DONE;
    iter     = (state == ITER) ? cnt : '0;
  end
endmodule

// File: tb/tb_goldschmidt_ctrl.sv
// tb_goldschmidt_ctrl: directed scoreboard bench for goldschmidt_ctrl
module tb_goldschmidt_ctrl;
  logic clk = 1'b0, reset, start, dZero, start1;
  logic ready, busy, ndSelect, kSelect, nEn, dEn, resultEn, done, err;
  logic [1:0] iter;
  logic ready1, busy1, ndSelect1, kSelect1, nEn1, dEn1, resultEn1, done1, err1;
  logic [1:0] iter1;
  int total = 0, bad = 0, cyc = 0, n_cnt = 0, r_cnt = 0;
  typedef struct {int due; logic e;} ent_t;
  ent_t q3[$];
  always #5 clk = ~clk;
  goldschmidt_ctrl #(.ITERS(3), .CNT_W(2)) u3 (
    .clk(clk), .reset(reset), .start(start), .dZero(dZero), .ready(ready), .busy(busy),
    .ndSelect(ndSelect), .kSelect(kSelect), .nEn(nEn), .dEn(dEn), .resultEn(resultEn),
    .done(done), .err(err), .iter(iter));
  goldschmidt_ctrl #(.ITERS(1), .CNT_W(2)) u1 (
    .clk(clk), .reset(reset), .start(start1), .dZero(1'b0), .ready(ready1), .busy(busy1),
    .ndSelect(ndSelect1), .kSelect(kSelect1), .nEn(nEn1), .dEn(dEn1), .resultEn(resultEn1),
    .done(done1), .err(err1), .iter(iter1));
  wire [15:0] o3 = {5'b0, ready, busy, ndSelect, kSelect, nEn, dEn, resultEn, done, err, iter};
  wire [15:0] o1 = {5'b0, ready1, busy1, ndSelect1, kSelect1, nEn1, dEn1, resultEn1, done1, err1, iter1};
  function automatic logic [15:0] mk(logic r, b, s, en, res, dn, er, logic [1:0] it);
    return {5'b0, r, b, s, s, en, en, res, dn, er, it};
  endfunction
  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(int n);
    ent_t e;
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      if (nEn) n_cnt++;
      if (resultEn) r_cnt++;
      if (done) begin
        chk("done_expected", 16'(q3.size() != 0), 16'd1);
        if (q3.size() != 0) begin
          e = q3.pop_front();
          chk("done_cycle", 16'(cyc), 16'(e.due));
          chk("done_err", 16'(err), 16'(e.e));
        end
      end
    end
  endtask
  task automatic push(int lat, logic e);
    q3.push_back('{cyc + lat, e});
  endtask
  initial begin
    reset = 1'b0; start = 1'b1; dZero = 1'b0; start1 = 1'b0;
    step(2);
    chk("rst_u3", o3, mk(1, 0, 0, 0, 0, 0, 0, 0));
    chk("rst_u1", o1, mk(1, 0, 0, 0, 0, 0, 0, 0));
    n_cnt = 0; r_cnt = 0;
    reset = 1'b1;
    push(5, 1'b0);
    step(1); start = 1'b0;
    chk("nom_load", o3, mk(0, 1, 0, 1, 0, 0, 0, 0));
    step(1); chk("nom_iter1", o3, mk(0, 1, 1, 1, 0, 0, 0, 1));
    step(1); chk("nom_iter2", o3, mk(0, 1, 1, 1, 0, 0, 0, 2));
    step(1); chk("nom_wb", o3, mk(0, 1, 0, 0, 1, 0, 0, 0));
    step(1); chk("nom_done", o3, mk(0, 0, 0, 0, 0, 1, 0, 0));
    step(1); chk("nom_idle", o3, mk(1, 0, 0, 0, 0, 0, 0, 0));
    chk("nom_nen_pulses", 16'(n_cnt), 16'd3);
    chk("nom_res_pulses", 16'(r_cnt), 16'd1);
    n_cnt = 0; r_cnt = 0;
    dZero = 1'b1; start = 1'b1;
    push(2, 1'b1);
    step(1); start = 1'b0;
    chk("dz_load", o3, mk(0, 1, 0, 1, 0, 0, 0, 0));
    step(1); chk("dz_done", o3, mk(0, 0, 0, 0, 0, 1, 1, 0));
    step(1); chk("dz_idle_err_held", o3, mk(1, 0, 0, 0, 0, 0, 1, 0));
    chk("dz_nen_pulses", 16'(n_cnt), 16'd1);
    chk("dz_res_pulses", 16'(r_cnt), 16'd0);
    dZero = 1'b0; start = 1'b1;
    push(5, 1'b0);
    step(1); start = 1'b0;
    chk("dz_next_load_err_clr", o3, mk(0, 1, 0, 1, 0, 0, 0, 0));
    step(5); chk("dz_next_idle", o3, mk(1, 0, 0, 0, 0, 0, 0, 0));
    r_cnt = 0;
    start = 1'b1;
    push(5, 1'b0);
    step(1); start = 1'b1;
    chk("busy_load", o3, mk(0, 1, 0, 1, 0, 0, 0, 0));
    step(1); start = 1'b0;
    chk("busy_iter1", o3, mk(0, 1, 1, 1, 0, 0, 0, 1));
    step(1); chk("busy_iter2", o3, mk(0, 1, 1, 1, 0, 0, 0, 2));
    start = 1'b0;
    step(1); start = 1'b1;
    chk("busy_wb", o3, mk(0, 1, 0, 0, 1, 0, 0, 0));
    step(1); start = 1'b0;
    chk("busy_done", o3, mk(0, 0, 0, 0, 0, 1, 0, 0));
    step(1); chk("busy_idle", o3, mk(1, 0, 0, 0, 0, 0, 0, 0));
    step(1); chk("busy_no_queue", o3, mk(1, 0, 0, 0, 0, 0, 0, 0));
    chk("busy_res_pulses", 16'(r_cnt), 16'd1);
    r_cnt = 0;
    start = 1'b1;
    step(1); start = 1'b0;
    step(1); chk("mid_iter1", o3, mk(0, 1, 1, 1, 0, 0, 0, 1));
    reset = 1'b0;
    step(1); chk("mid_rst_idle", o3, mk(1, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    step(1); chk("mid_stay_idle", o3, mk(1, 0, 0, 0, 0, 0, 0, 0));
    chk("mid_res_pulses", 16'(r_cnt), 16'd0);
    start = 1'b1;
    push(5, 1'b0);
    step(1); start = 1'b0;
    chk("mid_new_load", o3, mk(0, 1, 0, 1, 0, 0, 0, 0));
    step(1); chk("mid_new_iter1", o3, mk(0, 1, 1, 1, 0, 0, 0, 1));
    step(3); chk("mid_new_done", o3, mk(0, 0, 0, 0, 0, 1, 0, 0));
    step(1);
    start1 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step(1);
      case (k % 4)
        0: chk($sformatf("cont_load_%0d", k), o1, mk(0, 1, 0, 1, 0, 0, 0, 0));
        1: chk($sformatf("cont_wb_%0d", k), o1, mk(0, 1, 0, 0, 1, 0, 0, 0));
        2: chk($sformatf("cont_done_%0d", k), o1, mk(0, 0, 0, 0, 0, 1, 0, 0));
        default: chk($sformatf("cont_idle_%0d", k), o1, mk(1, 0, 0, 0, 0, 0, 0, 0));
      endcase
    end
    start1 = 1'b0;
    step(4);
    chk("u1_idle_end", o1, mk(1, 0, 0, 0, 0, 0, 0, 0));
    chk("q3_drained", 16'(q3.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/goldschmidt_ctrl.md
Name: goldschmidt_ctrl

Overview:
Sequencing FSM for the 16-bit Goldschmidt divider datapath (N, D, IA in; result out; ndSelect/kSelect muxes).
- Accepts a start request and steps the datapath through the initial IA scaling pass and the refinement iterations.
- Strobes the result register and returns a one-cycle done pulse.
- Flags divide-by-zero and aborts early on it.
- Sits between the top-level requester and the datapath; owns every datapath mux select and register enable.

Parameters:
ITERS, 3, total multiply passes including the IA pass (legal range 1..(2**CNT_W)-1)
CNT_W, 2, width of the iteration counter and iter port

Ports:
clk  input  1  system clock, all state updated on rising edge
reset  input  1  synchronous, active-low reset
start  input  1  request to begin a division; sampled only when ready=1
dZero  input  1  datapath flag, divisor operand D == 0; sampled only in LOAD
ready  output  1  high in IDLE only
busy  output  1  high in LOAD, ITER, WB
ndSelect  output  1  0 = datapath takes external N/D, 1 = fed-back N/D registers
kSelect  output  1  0 = K = IA, 1 = K = (2 - D) from datapath
nEn  output  1  N register load enable
dEn  output  1  D register load enable
resultEn  output  1  result register load enable
done  output  1  one-cycle completion pulse
err  output  1  sticky divide-by-zero flag for the last operation
iter  output  CNT_W  current pass index, 0 in LOAD

Behaviour:
- States: IDLE, LOAD, ITER, WB, DONE.
- Outputs are Moore, decoded from the state register, the counter and the err register only.
- No output depends combinationally on start or dZero.
- Reset (reset==0 at a rising edge):
  - state=IDLE, counter=0, err=0.
  - Outputs in IDLE: ready=1; busy, ndSelect, kSelect, nEn, dEn, resultEn and done all 0; iter=0.
  - Reset wins over every other event.
  - Reset mid-operation aborts with no done pulse and no resultEn.
- IDLE:
  - start=1 moves to LOAD and clears err.
  - start=0 stays in IDLE.
- LOAD (1 cycle):
  - ndSelect=0, kSelect=0, nEn=dEn=1, iter=0.
  - dZero=1: go to DONE, set err=1, suppress resultEn.
  - dZero=0: go to ITER if ITERS>1, otherwise WB. Counter becomes 1.
- ITER (ITERS-1 cycles):
  - ndSelect=1, kSelect=1, nEn=dEn=1, iter=counter.
  - counter==ITERS-1: go to WB.
  - Otherwise counter increments and the FSM stays in ITER.
- WB (1 cycle): resultEn=1, nEn=dEn=0, selects 0; next state DONE.
- DONE (1 cycle): done=1, ready=0, busy=0; next state IDLE. Counter clears to 0.
- Latency:
  - With start sampled at edge E0, done is high during cycle ITERS+2 after E0.
  - ITERS=3: LOAD, ITER, ITER, WB, DONE, so done appears in the 5th cycle.
  - Exactly ITERS nEn/dEn pulses per non-error operation.
- Handshake:
  - start while busy or in DONE is ignored. No queuing.
  - start held continuously gives back-to-back operations with one IDLE cycle between done and the next LOAD.
- err:
  - Valid from the DONE cycle.
  - Held until the next accepted start.
- Counter never wraps: the ITERS range guarantees ITERS-1 fits in CNT_W bits.

Test Plan:
- Reset: hold reset=0 for 2 cycles with start=1 -> ready=1; busy=0; done=0; all enables 0; iter=0; err=0. Release -> LOAD on the following edge.
- Nominal, ITERS=3, N=0x3000, D=0x2000, IA valid, start pulsed 1 cycle:
  - Trace per cycle: LOAD (ndSel=0,kSel=0,nEn=dEn=1), ITER iter=1, ITER iter=2 (ndSel=kSel=1), WB resultEn=1, DONE done=1.
  - Then ready=1. Exactly 3 nEn pulses, 1 resultEn pulse.
- Divide-by-zero: D=0x0000, dZero=1 in LOAD -> DONE in cycle 2, err=1, no ITER cycles, resultEn never 1. Next start with dZero=0 -> err clears in LOAD.
- start during operation: pulse start in the cycle after LOAD and again in WB -> no restart; single done; next op only after ready=1.
- Reset mid-ITER: reset=0 at iter=1 -> IDLE next edge, counter=0, no done or resultEn pulse. A new start then runs a full 5-cycle sequence.
- Continuous start=1 for 20 cycles with ITERS=1 -> repeating LOAD, WB, DONE, IDLE pattern. done every 4th cycle; no ITER state ever entered.
